// File: rtl/complex_pkg.sv
// Shared types for the complex row organizer back end.
//   ELEMENT_WIDTH      : width of one packed complex element
//   complex_t          : real part in [63:32], imaginary part in [31:0]
//   collector_state_t  : result collector FSM states
package complex_pkg;

    localparam int ELEMENT_WIDTH = 64;

    typedef struct packed {
        logic [31:0] real_part;
        logic [31:0] imag_part;
    } complex_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } collector_state_t;

endpackage

// File: rtl/complex_result_buffer.sv
// Register file holding one result vector.
//   clk      : write clock
//   wr_en    : write strobe
//   wr_addr  : write index
//   wr_data  : element to store
//   rd_addr  : read index
//   rd_data  : element at rd_addr (combinational)
module complex_result_buffer #(
    parameter int element_width = 64,
    parameter int NO_OF_ROWS    = 8,
    localparam int PTR_W        = $clog2(NO_OF_ROWS)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [PTR_W-1:0]         wr_addr,
    input  logic [element_width-1:0] wr_data,
    input  logic [PTR_W-1:0]         rd_addr,
    output logic [element_width-1:0] rd_data
);

    logic [element_width-1:0] mem [NO_OF_ROWS];

    // Contents are never reset; the FSM only reads entries it has written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/complex_row_result_collector.sv
// Collects NO_OF_ROWS finished complex row sums and streams them out as one
// ordered vector over a valid/ready interface.
//   clk, main_reset : clock, asynchronous active-high reset
//   start           : rising edge arms a collection, low level aborts one
//   result_in       : row sum, qualified by result_valid (one-cycle pulse)
//   out_data        : buffered entry at the read pointer
//   out_valid       : out_data valid (DRAIN)
//   out_ready       : consumer accepts out_data
//   out_last        : final entry of the vector
//   collect_done    : one-cycle pulse after the last entry is accepted
//   busy            : collecting or draining
//   overflow        : sticky, a result_valid arrived outside COLLECT
//   drop_count      : saturating count of dropped results
//                     (only when COLLECTOR_DROP_CNT_EN is defined)
module complex_row_result_collector
    import complex_pkg::*;
#(
    parameter int element_width = ELEMENT_WIDTH,
    parameter int NO_OF_ROWS    = 8
) (
    input  logic                     clk,
    input  logic                     main_reset,
    input  logic                     start,
    input  logic [element_width-1:0] result_in,
    input  logic                     result_valid,
    output logic [element_width-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     collect_done,
    output logic                     busy,
    output logic                     overflow
`ifdef COLLECTOR_DROP_CNT_EN
    ,
    output logic [7:0]               drop_count
`endif
);

    localparam int PTR_W = $clog2(NO_OF_ROWS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NO_OF_ROWS - 1);

    collector_state_t         state;
    collector_state_t         next_state;
    logic                     start_q;
    logic                     start_rise;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [element_width-1:0] rd_data;

    logic wr_en;
    logic wr_inc;
    logic rd_inc;
    logic ptr_clr;
    logic arm;
    logic drop;

    assign start_rise = start && !start_q;

    always_ff @(posedge clk or posedge main_reset) begin
        if (main_reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= next_state;
            start_q <= start;
        end
    end

    always_comb begin
        next_state   = state;
        wr_en        = 1'b0;
        wr_inc       = 1'b0;
        rd_inc       = 1'b0;
        ptr_clr      = 1'b0;
        arm          = 1'b0;
        drop         = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        collect_done = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
                drop = result_valid;
                if (start_rise) begin
                    next_state = COLLECT;
                    arm        = 1'b1;
                end
            end
            COLLECT: begin
                busy = 1'b1;
                // A low start aborts even when a result arrives in the same cycle.
                if (!start) begin
                    next_state = IDLE;
                    ptr_clr    = 1'b1;
                end else if (result_valid) begin
                    wr_en = 1'b1;
                    // The pointer holds at the last index instead of wrapping.
                    if (wr_ptr == LAST_IDX) begin
                        next_state = DRAIN;
                    end else begin
                        wr_inc = 1'b1;
                    end
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (rd_ptr == LAST_IDX);
                drop      = result_valid;
                if (out_ready) begin
                    if (rd_ptr == LAST_IDX) begin
                        next_state = DONE;
                    end else begin
                        rd_inc = 1'b1;
                    end
                end
            end
            DONE: begin
                collect_done = 1'b1;
                drop         = result_valid;
                next_state   = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge main_reset) begin
        if (main_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (arm || ptr_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_inc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_inc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Arming clears the flag even if a drop lands on the same edge.
    always_ff @(posedge clk or posedge main_reset) begin
        if (main_reset) begin
            overflow <= 1'b0;
        end else if (arm) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef COLLECTOR_DROP_CNT_EN
    always_ff @(posedge clk or posedge main_reset) begin
        if (main_reset) begin
            drop_count <= '0;
        end else if (arm) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

    complex_result_buffer #(
        .element_width (element_width),
        .NO_OF_ROWS    (NO_OF_ROWS)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (result_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Forced to zero outside DRAIN so reset and idle show a clean bus.
    assign out_data = out_valid ? rd_data : '0;

endmodule

// File: tb/tb_complex_row_result_collector.sv
// Self-checking bench for complex_row_result_collector (NO_OF_ROWS = 8).
// A queue-based reference model is advanced once per cycle and compared
// against the DUT outputs; directed tests add literal expectations.
module tb_complex_row_result_collector;

    localparam int N = 8;
    localparam int M_IDLE = 0, M_COLLECT = 1, M_DRAIN = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        main_reset;
    logic        start;
    logic [63:0] result_in;
    logic        result_valid;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        collect_done;
    logic        busy;
    logic        overflow;
`ifdef COLLECTOR_DROP_CNT_EN
    logic [7:0]  drop_count;
`endif

    complex_row_result_collector #(
        .element_width (64),
        .NO_OF_ROWS    (N)
    ) dut (
        .clk          (clk),
        .main_reset   (main_reset),
        .start        (start),
        .result_in    (result_in),
        .result_valid (result_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .collect_done (collect_done),
        .busy         (busy),
        .overflow     (overflow)
`ifdef COLLECTOR_DROP_CNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: what has been collected and where the drain stands.
    int          m_mode;
    logic [63:0] m_vec[$];
    int          m_idx;
    logic        m_prev_start;
    logic        m_ov;
    int          m_drops;

    // Observations of the output stream.
    logic [63:0] got[$];
    int done_cnt = 0;
    int last_cnt = 0;
    int valid_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_vec.delete();
        m_idx = 0;
        m_prev_start = 1'b0;
        m_ov = 1'b0;
        m_drops = 0;
    endtask

    task automatic model_drop();
        m_ov = 1'b1;
        if (m_drops < 255) m_drops++;
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        case (m_mode)
            M_IDLE: begin
                if (result_valid) model_drop();
                if (start && !m_prev_start) begin
                    m_mode = M_COLLECT;
                    m_vec.delete();
                    m_ov = 1'b0;
                    m_drops = 0;
                end
            end
            M_COLLECT: begin
                if (!start) begin
                    m_vec.delete();
                    m_mode = M_IDLE;
                end else if (result_valid) begin
                    m_vec.push_back(result_in);
                    if (m_vec.size() == N) begin
                        m_mode = M_DRAIN;
                        m_idx = 0;
                    end
                end
            end
            M_DRAIN: begin
                if (result_valid) model_drop();
                if (out_ready) begin
                    if (m_idx == N - 1) m_mode = M_DONE;
                    else m_idx++;
                end
            end
            default: begin
                if (result_valid) model_drop();
                m_mode = M_IDLE;
            end
        endcase
        m_prev_start = start;
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (main_reset) model_reset();
            chk("out_valid", 64'(out_valid), 64'(m_mode == M_DRAIN));
            chk("out_last", 64'(out_last), 64'(m_mode == M_DRAIN && m_idx == N - 1));
            chk("collect_done", 64'(collect_done), 64'(m_mode == M_DONE));
            chk("busy", 64'(busy), 64'(m_mode == M_COLLECT || m_mode == M_DRAIN));
            chk("overflow", 64'(overflow), 64'(m_ov));
            if (m_mode == M_DRAIN) chk("out_data", out_data, m_vec[m_idx]);
`ifdef COLLECTOR_DROP_CNT_EN
            chk("drop_count", 64'(drop_count), 64'(m_drops));
`endif
            if (!main_reset) begin
                if (out_valid && out_ready) begin
                    got.push_back(out_data);
                    if (out_last) last_cnt++;
                end
                if (out_valid) valid_cycles++;
                if (collect_done) done_cnt++;
                model_step();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] v);
        result_in = v;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
    endtask

    // Waits for collect_done; with bp set, out_ready follows the 1,0,0,1 pattern.
    task automatic wait_done(input string name, input bit bp);
        int base;
        int k;
        logic [3:0] pat;
        base = done_cnt;
        k = 0;
        pat = 4'b1001;
        while (done_cnt == base && k < 100) begin
            if (bp) out_ready = pat[k % 4];
            tick();
            k++;
        end
        chk(name, 64'(done_cnt != base), 64'd1);
    endtask

    task automatic check_vec(input string name, input int base, input logic [63:0] first, input logic [63:0] step);
        chk({name, "_count"}, 64'(got.size() - base), 64'(N));
        for (int i = 0; i < N; i++) begin
            if (base + i < got.size())
                chk(name, got[base + i], first + step * 64'(i));
        end
    endtask

    initial begin
        int gb;
        int lb;
        int db;
        int vb;
        main_reset = 1'b1;
        start = 1'b0;
        result_valid = 1'b0;
        result_in = '0;
        out_ready = 1'b0;
        model_reset();
        fork
            compare_loop();
        join_none
        repeat (3) tick();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", out_data, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        main_reset = 1'b0;
        tick();

        // Normal run: results 3 cycles apart, out_ready high.
        gb = got.size(); lb = last_cnt; db = done_cnt; vb = valid_cycles;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        for (int i = 0; i < N; i++) begin
            send(64'h0000_0001_0000_0000 + 64'(i));
            tick();
            tick();
        end
        wait_done("normal_done", 1'b0);
        check_vec("normal_data", gb, 64'h0000_0001_0000_0000, 64'd1);
        chk("normal_last_once", 64'(last_cnt - lb), 64'd1);
        chk("normal_done_once", 64'(done_cnt - db), 64'd1);
        chk("normal_zero_bubble", 64'(valid_cycles - vb), 64'(N));
        chk("normal_busy_after", 64'(busy), 64'd0);
        start = 1'b0;
        tick();

        // Back-to-back capture then drain under 1,0,0,1 backpressure.
        gb = got.size();
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        for (int i = 0; i < N; i++) send(64'hA5A5_0000_0000_0100 + 64'(i) * 64'h11);
        wait_done("bp_done", 1'b1);
        check_vec("bp_data", gb, 64'hA5A5_0000_0000_0100, 64'h11);
        start = 1'b0;
        out_ready = 1'b1;
        tick();

        // Abort after 5 results, then abort coinciding with the final result.
        vb = valid_cycles; db = done_cnt;
        start = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) send(64'hBEEF_0000_0000_0000 + 64'(i));
        start = 1'b0;
        repeat (3) tick();
        chk("abort_busy", 64'(busy), 64'd0);
        start = 1'b1;
        tick();
        for (int i = 0; i < N - 1; i++) send(64'hF00D_0000_0000_0000 + 64'(i));
        start = 1'b0;
        send(64'hF00D_0000_0000_0007);
        repeat (3) tick();
        chk("abort_no_valid", 64'(valid_cycles - vb), 64'd0);
        chk("abort_no_done", 64'(done_cnt - db), 64'd0);
        chk("abort_overflow_clear", 64'(overflow), 64'd0);
        gb = got.size();
        start = 1'b1;
        tick();
        for (int i = 0; i < N; i++) send(64'hC0DE_0000_0000_0010 + 64'(i) * 64'd2);
        wait_done("abort_new_done", 1'b0);
        check_vec("abort_new_data", gb, 64'hC0DE_0000_0000_0010, 64'd2);
        start = 1'b0;
        tick();

        // Drops: one in IDLE (cleared by arming), one in DRAIN, one in IDLE after.
        send(64'hDEAD_DEAD_DEAD_DEAD);
        chk("drop_idle_overflow", 64'(overflow), 64'd1);
        gb = got.size();
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        chk("drop_arm_clears", 64'(overflow), 64'd0);
        for (int i = 0; i < N; i++) send(64'h1234_0000_0000_0000 + 64'(i) * 64'h100);
        send(64'hBAD0_BAD0_BAD0_BAD0);
        chk("drop_drain_overflow", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        wait_done("drop_done", 1'b0);
        check_vec("drop_data", gb, 64'h1234_0000_0000_0000, 64'h100);
        start = 1'b0;
        tick();
        send(64'hBAD1_BAD1_BAD1_BAD1);
        chk("drop_sticky", 64'(overflow), 64'd1);
`ifdef COLLECTOR_DROP_CNT_EN
        chk("drop_count_two", 64'(drop_count), 64'd2);
`endif
        tick();

        // Back-to-back capture, then reset in the middle of the drain.
        gb = got.size();
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        for (int i = 0; i < N; i++) send(64'h7700_0000_0000_0000 + 64'(i));
        out_ready = 1'b1;
        repeat (5) tick();
        chk("rst_partial_first", got[gb], 64'h7700_0000_0000_0000);
        chk("rst_partial_fourth", got[gb + 4], 64'h7700_0000_0000_0004);
        main_reset = 1'b1;
        start = 1'b0;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        chk("rst_async_last", 64'(out_last), 64'd0);
        chk("rst_async_data", out_data, 64'd0);
        chk("rst_async_done", 64'(collect_done), 64'd0);
        chk("rst_async_busy", 64'(busy), 64'd0);
        chk("rst_async_overflow", 64'(overflow), 64'd0);
        repeat (2) tick();
        main_reset = 1'b0;
        repeat (3) tick();
        chk("rst_idle_busy", 64'(busy), 64'd0);
        chk("rst_idle_valid", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/complex_row_result_collector.md
# complex_row_result_collector

Downstream stage of the complex eight-element row organizer. It captures each finished complex row sum from the organizer's final adder into an on-chip buffer. Once a full result vector of NO_OF_ROWS entries has been collected, it streams the vector out over a valid/ready interface. It turns the organizer's one-cycle finish pulses into a complete, ordered result vector for the next stage (write-back or host readout).

## Interface
Parameters:
- element_width, 64, width of one complex element: real part in [63:32], imaginary part in [31:0]
- NO_OF_ROWS, 8, number of row results per vector; must be ≥ 2

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- main_reset  input  1  asynchronous, active-high reset
- start  input  1  same start level that enables the organizer; a rising edge arms a new collection, and a low level aborts one
- result_in  input  element_width  row sum from the organizer's adder_output
- result_valid  input  1  organizer's final_adder_finish_dash; one-cycle pulse qualifying result_in
- out_data  output  element_width  buffered result at the read pointer
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts out_data
- out_last  output  1  marks the final entry of the vector
- collect_done  output  1  one-cycle pulse after the last entry is accepted
- busy  output  1  high in COLLECT and DRAIN
- overflow  output  1  sticky flag: a result_valid arrived outside COLLECT

## Operation
- States:
  - IDLE: waiting for a start rising edge.
  - COLLECT: accepting row results.
  - DRAIN: streaming the buffer out.
  - DONE: single cycle that raises collect_done.
- start edge detection: start is registered (start_q). A rising edge is start && !start_q.
- IDLE → COLLECT on a start rising edge. Entry clears wr_ptr, rd_ptr and overflow.
- In COLLECT, each result_valid writes buffer[wr_ptr] = result_in and increments wr_ptr.
- COLLECT → DRAIN on the result_valid that writes index NO_OF_ROWS-1.
- COLLECT → IDLE if start goes low before the vector completes. Partial data is discarded, both pointers clear, and collect_done is not raised.
- DRAIN:
  - out_valid = 1 and out_data = buffer[rd_ptr].
  - A handshake is out_valid && out_ready; each handshake increments rd_ptr.
  - out_last = 1 while rd_ptr == NO_OF_ROWS-1.
  - A handshake with out_last set moves the FSM to DONE.
  - out_data must hold stable while out_valid && !out_ready.
  - start is ignored in DRAIN; it cannot abort a drain.
- DONE → IDLE unconditionally. A new collection requires a fresh start rising edge, so a start held high does not re-arm.
- A result_valid in IDLE, DRAIN or DONE is dropped: the buffer is not written and overflow is set.
- Pointer widths are $clog2(NO_OF_ROWS). Pointers never wrap, because the state changes at the last index.
- Data passes through unmodified. There is no arithmetic on the payload.

## Timing
- Reset values: state = IDLE, all pointers 0, start_q = 0, out_valid = 0, out_last = 0, out_data = 0, collect_done = 0, busy = 0, overflow = 0.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronous). Buffer contents need not be cleared.
- Capture latency: result_valid sampled at edge N makes the data visible in the buffer after edge N.
- The last write at edge N gives out_valid = 1 in the cycle after edge N.
- Zero-bubble drain: with out_ready held high, NO_OF_ROWS transfers take NO_OF_ROWS consecutive cycles.
- collect_done is high for exactly one cycle, the cycle after the last handshake.
- Back-to-back result_valid on consecutive cycles must be accepted; each cycle writes one entry.
- If start falls in the same cycle as the final result_valid, the abort wins: the FSM goes to IDLE and nothing is written.

## Configuration
- COLLECTOR_DROP_CNT_EN defined:
  - Adds output drop_count [7:0].
  - It counts every dropped result_valid and saturates at 255.
  - It clears on reset and on COLLECT entry.
- COLLECTOR_DROP_CNT_EN undefined: no drop_count port or logic exists; overflow alone reports drops.

## Structure
- Shared package complex_pkg holds:
  - ELEMENT_WIDTH
  - the complex_t struct (real [31:0], imag [31:0])
  - the collector_state_t enum (IDLE, COLLECT, DRAIN, DONE)
- Sub-module complex_result_buffer: an NO_OF_ROWS × element_width register file with one synchronous write port and one combinational read port. The top level holds the FSM, pointers and flags.

## Test plan
- Normal run:
  - Stimulus: NO_OF_ROWS = 8; start rises; 8 result_valid pulses spaced 3 cycles apart carrying 0x0000000100000000 + i; out_ready held high.
  - Response: 8 consecutive outputs in order i = 0..7; out_last only on i = 7; collect_done pulses once; busy drops afterwards.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 repeatedly during DRAIN.
  - Response: out_data holds stable while stalled; no entry is lost or repeated.
- Abort:
  - Stimulus: start falls after 5 of 8 results.
  - Response: FSM returns to IDLE; out_valid never rises. A new start followed by 8 results outputs only the new values.
- Drop:
  - Stimulus: result_valid pulses in IDLE, and again during DRAIN.
  - Response: overflow = 1; drained data is unchanged; with COLLECTOR_DROP_CNT_EN, drop_count = 2.
- Back-to-back and reset:
  - Stimulus: 8 result_valid pulses on consecutive cycles, then main_reset asserted mid-DRAIN.
  - Response: all 8 entries are captured; on reset, outputs immediately return to reset values and the state is IDLE.
